dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the MEM stage's load/store port.
//  - Accepts one request at a time over a valid/ready handshake.
//  - Inserts a programmable number of wait states.
//  - Performs byte/half/word access into an internal word-addressed RAM.
//  - Returns sign/zero-extended load data and an error flag over a second valid/ready channel.
//  - Models a slow data memory so the pipeline's stall logic can be exercised.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM size in 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1
//  WAIT_STATES  2     extra cycles between acceptance and response, range 0..15
// PORTS
//  clk         in   1   single clock, all state updates on rising edge
//  reset       in   1   synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; high only in IDLE
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; the low byte/half/word is used according to size
//  req_funct3  in   3   RV32I funct3: LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   consumer accepts response
//  rsp_rdata   out  32  load result, extended per funct3; 0 for stores and errors
//  rsp_err     out  1   request rejected: misaligned, out of range, or illegal funct3
// BEHAVIOUR
//  Reset values
//  - state=IDLE, req_ready=1 from the first cycle after reset.
//  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//  - RAM contents are not reset.
//  FSM states: IDLE, WAIT, RESP
//  - IDLE: accept when req_valid&&req_ready; latch write, addr, wdata, funct3.
//    - Go to WAIT if WAIT_STATES>0 (counter loads WAIT_STATES-1); otherwise go to RESP.
//  - WAIT: decrement the counter; move to RESP on the edge where the counter is 0.
//  - RESP: hold rsp_valid/rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready, then go to IDLE.
//  Latency and throughput
//  - rsp_valid rises exactly WAIT_STATES+1 cycles after the accepting edge.
//  - No acceptance in WAIT or RESP, so the minimum request spacing is WAIT_STATES+2 cycles.
//  - A rsp_ready stall extends RESP indefinitely.
//  Access timing
//  - The RAM write and the RAM read happen on the edge entering RESP.
//  - A store is therefore committed exactly when its response becomes valid.
//  Layout and alignment
//  - Little-endian. Byte lane = addr[1:0]; half lane = addr[1]; word index = addr[31:2].
//  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//  Error detection
//  - Checked at acceptance: misaligned, word index >= DEPTH_WORDS, or illegal funct3.
//  - Illegal funct3: loads 011/110/111; stores any value other than 000/001/010.
//  - Error case: no RAM write, rsp_err=1, rsp_rdata=0, same latency as a legal access.
//  Stores
//  - Write only the addressed byte lanes; other bytes of the word are unchanged.
//  - rsp_rdata=0 on the store response.
//  Loads
//  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW returns the full word.
//  Reset mid-operation
//  - Reset in WAIT abandons the request; its store is never written.
//  - Reset in RESP drops the response; the store already committed remains in RAM.
//  Request inputs are ignored outside IDLE; the requester must hold them stable while req_valid&&!req_ready.
// TESTING
//  1 reset; SW addr=0x10 wdata=0xDEADBEEF; LW 0x10 -> rdata=0xDEADBEEF, err=0; rsp_valid 3 cycles after accept (WAIT_STATES=2).
//  2 SB 0x11 wdata=0x80; LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
//  3 LH 0x13 -> err=1, rdata=0; SW 4*DEPTH_WORDS -> err=1, and a LW of word 0 shows it unchanged.
//  4 hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0 throughout; accept resumes the cycle after the handshake.
//  5 SW 0x20 0x12345678, then assert reset 1 cycle after accept (in WAIT) -> LW 0x20 returns the old value; req_ready=1 after reset.
//  6 WAIT_STATES=0 build: back-to-back LW requests -> each response 1 cycle after accept, accepts spaced 2 cycles apart.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: slow data-memory model for the MEM stage load/store port.
// One request in flight, programmable wait states, byte/half/word access.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   req_valid/ready   request handshake; ready is high only while idle
//   req_write         1 = store, 0 = load
//   req_addr          byte address (little-endian)
//   req_wdata         store data, low byte/half/word used per size
//   req_funct3        RV32I load/store funct3
//   rsp_valid/ready   response handshake
//   rsp_rdata         extended load data; 0 for stores and errors
//   rsp_err           misaligned, out of range or illegal funct3
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW =
      (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [3:0] CNT_INIT =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   logic [3:0]  cnt;

   logic        lat_write;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [2:0]  lat_funct3;

   logic [31:0] mem [DEPTH_WORDS];

   logic        src_write;
   logic [31:0] src_addr;
   logic [31:0] src_wdata;
   logic [2:0]  src_funct3;

   logic        commit;
   logic        f3_ok;
   logic        misaligned;
   logic        out_of_range;
   logic        src_err;

   logic [AW-1:0] idx;
   logic [31:0]   rd_word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   ld_data;
   logic [31:0]   rsp_data_n;

   logic [3:0]  be;
   logic [31:0] wd;

   // With no wait states the access happens on the
   // accepting edge, so it must see the live request.
   always_comb begin
      src_write  = lat_write;
      src_addr   = lat_addr;
      src_wdata  = lat_wdata;
      src_funct3 = lat_funct3;
      if (state == IDLE) begin
         src_write  = req_write;
         src_addr   = req_addr;
         src_wdata  = req_wdata;
         src_funct3 = req_funct3;
      end
   end

   // High on the edge that enters RESP.
   always_comb begin
      commit = 1'b0;
      if (!reset) begin
         unique case (state)
            IDLE:
               commit = req_valid && req_ready &&
                        (WAIT_STATES == 0);
            WAIT:
               commit = (cnt == 4'd0);
            default:
               commit = 1'b0;
         endcase
      end
   end

   always_comb begin
      f3_ok = 1'b0;
      unique case (src_funct3)
         3'b000, 3'b001, 3'b010:
            f3_ok = 1'b1;
         3'b100, 3'b101:
            f3_ok = !src_write;
         default:
            f3_ok = 1'b0;
      endcase
   end

   always_comb begin
      misaligned =
         ((src_funct3[1:0] == 2'b01) && src_addr[0]) ||
         ((src_funct3[1:0] == 2'b10) &&
          (src_addr[1:0] != 2'b00));
      out_of_range =
         ({2'b00, src_addr[31:2]} >= 32'(DEPTH_WORDS));
      src_err = !f3_ok || misaligned || out_of_range;
   end

   assign idx     = src_addr[AW+1:2];
   assign rd_word = mem[idx];

   always_comb begin
      byte_sel = rd_word[8*src_addr[1:0] +: 8];
      half_sel = src_addr[1] ? rd_word[31:16]
                             : rd_word[15:0];
   end

   always_comb begin
      ld_data = rd_word;
      unique case (src_funct3)
         3'b000:
            ld_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:
            ld_data = {{16{half_sel[15]}}, half_sel};
         3'b100:
            ld_data = {24'd0, byte_sel};
         3'b101:
            ld_data = {16'd0, half_sel};
         default:
            ld_data = rd_word;
      endcase
   end

   assign rsp_data_n =
      (src_write || src_err) ? 32'd0 : ld_data;

   // Replicate store data across lanes; the enables
   // pick which lanes actually land in the word.
   always_comb begin
      be = 4'b1111;
      wd = src_wdata;
      unique case (src_funct3[1:0])
         2'b00: begin
            be = 4'b0001 << src_addr[1:0];
            wd = {4{src_wdata[7:0]}};
         end
         2'b01: begin
            be = src_addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{src_wdata[15:0]}};
         end
         default: begin
            be = 4'b1111;
            wd = src_wdata;
         end
      endcase
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (commit && src_write && !src_err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 32'd0;
         rsp_err    <= 1'b0;
         lat_write  <= 1'b0;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
         lat_funct3 <= 3'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  lat_write  <= req_write;
                  lat_addr   <= req_addr;
                  lat_wdata  <= req_wdata;
                  lat_funct3 <= req_funct3;
                  req_ready  <= 1'b0;
                  if (WAIT_STATES > 0) begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end else begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rsp_data_n;
                     rsp_err   <= src_err;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rsp_data_n;
                  rsp_err   <= src_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'd0;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rsp_rdata <= 32'd0;
               rsp_err   <= 1'b0;
            end
         endcase
      end
   end

endmodule
